// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared FSM states, lane constants and error helper for dmem_responder
package dmem_responder_pkg;

    localparam int DR_DWIDTH = 32;
    localparam int DR_MASK_W = 4;
    localparam int DR_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dr_state_e;

    // A full-word store/load must start on a word boundary.
    function automatic logic dr_misaligned(input logic [DR_MASK_W-1:0] mask,
                                           input logic [1:0] addr_lo);
        return (mask == {DR_MASK_W{1'b1}}) && (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bundle between the memory stage and dmem_responder
interface dmem_responder_if #(
    parameter int DWIDTH = 32
);
    import dmem_responder_pkg::*;

    logic                 dr_i_req;
    logic                 dr_i_we;
    logic [DWIDTH-1:0]    dr_i_addr;
    logic [DR_MASK_W-1:0] dr_i_mask;
    logic [DWIDTH-1:0]    dr_i_wdata;
    logic                 dr_o_ack;
    logic [DWIDTH-1:0]    dr_o_rdata;
    logic                 dr_o_busy;
    logic                 dr_o_err;

    modport master (
        output dr_i_req, dr_i_we, dr_i_addr, dr_i_mask, dr_i_wdata,
        input  dr_o_ack, dr_o_rdata, dr_o_busy, dr_o_err
    );

    modport slave (
        input  dr_i_req, dr_i_we, dr_i_addr, dr_i_mask, dr_i_wdata,
        output dr_o_ack, dr_o_rdata, dr_o_busy, dr_o_err
    );

endinterface

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - byte-lane word array with enable-gated masked write and registered read
module dmem_bank
    import dmem_responder_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DR_MASK_W-1:0]  mask,
    input  logic [DWIDTH-1:0]     wdata,
    output logic [DWIDTH-1:0]     rdata
);

    localparam int LANE_W = DWIDTH / DR_MASK_W;
    localparam int DEPTH  = 1 << DEPTH_LOG2;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rdata_d, rdata_q;

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < DR_MASK_W; i++) begin
                if (mask[i]) begin
                    mem_q[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder; DR_ERR_CHECK_EN enables range/alignment errors
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             dr_clk,
    input  logic             dr_rst,
    dmem_responder_if.slave  dr
);

    localparam logic [DR_CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? '0 : DR_CNT_W'(WAIT_CYCLES - 1);
    localparam dr_state_e FIRST_STATE = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;

    dr_state_e               state_d, state_q;
    logic [DR_CNT_W-1:0]     cnt_d, cnt_q;
    logic                    we_d, we_q;
    logic [DWIDTH-1:0]       addr_d, addr_q;
    logic [DR_MASK_W-1:0]    mask_d, mask_q;
    logic [DWIDTH-1:0]       wdata_d, wdata_q;
    logic                    ack_d, ack_q;
    logic                    err_d, err_q;
    logic                    rd_zero_d, rd_zero_q;
    logic                    acc_err;
    logic                    bank_en;
    logic [DWIDTH-1:0]       bank_rdata;

`ifdef DR_ERR_CHECK_EN
    assign acc_err = (|addr_q[DWIDTH-1:DEPTH_LOG2+2]) || dr_misaligned(mask_q, addr_q[1:0]);
`else
    // Without checks the high address bits simply wrap onto the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_q[DWIDTH-1:DEPTH_LOG2+2], addr_q[1:0]};
    assign acc_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        wdata_d   = wdata_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rd_zero_d = rd_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (dr.dr_i_req) begin
                    we_d    = dr.dr_i_we;
                    addr_d  = dr.dr_i_addr;
                    mask_d  = dr.dr_i_mask;
                    wdata_d = dr.dr_i_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = FIRST_STATE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                // Access happens this cycle; ack and read data land together on the next edge.
                ack_d   = 1'b1;
                err_d   = acc_err;
                if (!we_q) begin
                    rd_zero_d = acc_err;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge dr_clk or negedge dr_rst) begin
        if (!dr_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            mask_q    <= '0;
            wdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            wdata_q   <= wdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rd_zero_q <= rd_zero_d;
        end
    end

    assign bank_en = (state_q == ST_RESP) && !acc_err;

    dmem_bank #(
        .DWIDTH     (DWIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
        .clk   (dr_clk),
        .rst_n (dr_rst),
        .en    (bank_en),
        .we    (we_q),
        .addr  (addr_q[DEPTH_LOG2+1:2]),
        .mask  (mask_q),
        .wdata (wdata_q),
        .rdata (bank_rdata)
    );

    assign dr.dr_o_ack   = ack_q;
    assign dr.dr_o_err   = err_q;
    assign dr.dr_o_rdata = rd_zero_q ? '0 : bank_rdata;
    assign dr.dr_o_busy  = dr.dr_i_req & ~ack_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (WAIT_CYCLES = 2)
module tb_dmem_responder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dmem_responder_if #(.DWIDTH(32)) dr();

    dmem_responder #(
        .DWIDTH      (32),
        .DEPTH_LOG2  (10),
        .WAIT_CYCLES (2)
    ) dut (
        .dr_clk (clk),
        .dr_rst (rst_n),
        .dr     (dr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                             input logic [31:0] wdata, output int n, output logic busy_pre,
                             output logic busy_ack, output logic [31:0] rdata,
                             output logic err, output logic ack_after);
        logic got;
        @(negedge clk);
        dr.dr_i_we    = we;
        dr.dr_i_addr  = addr;
        dr.dr_i_mask  = mask;
        dr.dr_i_wdata = wdata;
        dr.dr_i_req   = 1'b1;
        n        = 0;
        got      = 1'b0;
        busy_pre = 1'b1;
        busy_ack = 1'bx;
        rdata    = 'x;
        err      = 1'bx;
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (dr.dr_o_ack) begin
                got      = 1'b1;
                busy_ack = dr.dr_o_busy;
                rdata    = dr.dr_o_rdata;
                err      = dr.dr_o_err;
            end else begin
                busy_pre = busy_pre & dr.dr_o_busy;
            end
        end
        if (!got) n = -1;
        dr.dr_i_req = 1'b0;
        @(posedge clk);
        #1;
        ack_after = dr.dr_o_ack;
    endtask

    task automatic test_reset();
        int n;
        rst_n         = 1'b0;
        dr.dr_i_req   = 1'b1;
        dr.dr_i_we    = 1'b1;
        dr.dr_i_addr  = 32'h0;
        dr.dr_i_mask  = 4'hF;
        dr.dr_i_wdata = 32'h1234_5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (dr.dr_o_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", dr.dr_o_ack); end
        checks++; if (dr.dr_o_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", dr.dr_o_err); end
        checks++; if (dr.dr_o_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", dr.dr_o_rdata); end
        checks++; if (dr.dr_o_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", dr.dr_o_busy); end
        rst_n = 1'b1;
        n = 0;
        while (n < 20 && !(n > 0 && dr.dr_o_ack === 1'b1)) begin
            @(posedge clk);
            #1;
            n++;
        end
        dr.dr_i_req = 1'b0;
        checks++; if (n !== 4) begin errors++; $display("FAIL reset_first_accept got=%0d exp=4", n); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        int n; logic bp, ba, e, aa; logic [31:0] rd;
        do_access(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, n, bp, ba, rd, e, aa);
        checks++; if (n !== 4) begin errors++; $display("FAIL store_latency got=%0d exp=4", n); end
        checks++; if (bp !== 1'b1) begin errors++; $display("FAIL store_busy_pre got=%b exp=1", bp); end
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL store_busy_ack got=%b exp=0", ba); end
        checks++; if (aa !== 1'b0) begin errors++; $display("FAIL store_ack_width got=%b exp=0", aa); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL store_err got=%b exp=0", e); end
        do_access(1'b0, 32'h10, 4'h0, 32'h0, n, bp, ba, rd, e, aa);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_word got=%h exp=deadbeef", rd); end
        checks++; if (n !== 4) begin errors++; $display("FAIL load_latency got=%0d exp=4", n); end
    endtask

    task automatic test_byte_store();
        int n; logic bp, ba, e, aa; logic [31:0] rd;
        do_access(1'b1, 32'h10, 4'b0100, 32'h00AA_0000, n, bp, ba, rd, e, aa);
        do_access(1'b0, 32'h10, 4'h0, 32'h0, n, bp, ba, rd, e, aa);
        checks++; if (rd !== 32'hDEAA_BEEF) begin errors++; $display("FAIL byte_store got=%h exp=deaabeef", rd); end
        do_access(1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, n, bp, ba, rd, e, aa);
        checks++; if (n !== 4) begin errors++; $display("FAIL zero_mask_ack got=%0d exp=4", n); end
        do_access(1'b0, 32'h10, 4'h0, 32'h0, n, bp, ba, rd, e, aa);
        checks++; if (rd !== 32'hDEAA_BEEF) begin errors++; $display("FAIL zero_mask_nochange got=%h exp=deaabeef", rd); end
    endtask

    task automatic test_back_to_back();
        int acks, e1, e2, n; logic bp, ba, e, aa; logic [31:0] rd;
        acks = 0; e1 = 0; e2 = 0;
        @(negedge clk);
        dr.dr_i_we    = 1'b1;
        dr.dr_i_addr  = 32'h40;
        dr.dr_i_mask  = 4'hF;
        dr.dr_i_wdata = 32'hA5A5_A5A5;
        dr.dr_i_req   = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (dr.dr_o_ack === 1'b1) begin
                acks++;
                if (acks == 1) begin
                    e1 = c;
                    dr.dr_i_addr  = 32'h44;
                    dr.dr_i_wdata = 32'h5A5A_5A5A;
                end else if (acks == 2) begin
                    e2 = c;
                    dr.dr_i_req = 1'b0;
                end
            end
        end
        dr.dr_i_req = 1'b0;
        checks++; if (acks !== 2) begin errors++; $display("FAIL b2b_ack_count got=%0d exp=2", acks); end
        checks++; if (e2 - e1 !== 4) begin errors++; $display("FAIL b2b_spacing got=%0d exp=4", e2 - e1); end
        do_access(1'b0, 32'h40, 4'h0, 32'h0, n, bp, ba, rd, e, aa);
        checks++; if (rd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL b2b_word0 got=%h exp=a5a5a5a5", rd); end
        do_access(1'b0, 32'h44, 4'h0, 32'h0, n, bp, ba, rd, e, aa);
        checks++; if (rd !== 32'h5A5A_5A5A) begin errors++; $display("FAIL b2b_word1 got=%h exp=5a5a5a5a", rd); end
    endtask

    task automatic test_errors();
        int n; logic bp, ba, e, aa; logic [31:0] rd;
        do_access(1'b0, 32'h0000_1000, 4'h0, 32'h0, n, bp, ba, rd, e, aa);
`ifdef DR_ERR_CHECK_EN
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL range_err got=%b exp=1", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL range_rdata got=%h exp=0", rd); end
        do_access(1'b1, 32'h12, 4'hF, 32'h0BAD_0BAD, n, bp, ba, rd, e, aa);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL align_err got=%b exp=1", e); end
        do_access(1'b0, 32'h10, 4'h0, 32'h0, n, bp, ba, rd, e, aa);
        checks++; if (rd !== 32'hDEAA_BEEF) begin errors++; $display("FAIL align_nowrite got=%h exp=deaabeef", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL good_load_err got=%b exp=0", e); end
`else
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL wrap_load got=%h exp=12345678", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wrap_err got=%b exp=0", e); end
`endif
    endtask

    task automatic test_reset_in_wait();
        int n, acks; logic bp, ba, e, aa; logic [31:0] rd;
        do_access(1'b1, 32'h20, 4'hF, 32'h1111_1111, n, bp, ba, rd, e, aa);
        @(negedge clk);
        dr.dr_i_we    = 1'b1;
        dr.dr_i_addr  = 32'h20;
        dr.dr_i_mask  = 4'hF;
        dr.dr_i_wdata = 32'hCAFE_F00D;
        dr.dr_i_req   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (dr.dr_o_ack !== 1'b0) begin errors++; $display("FAIL rst_wait_ack got=%b exp=0", dr.dr_o_ack); end
        @(negedge clk);
        dr.dr_i_req = 1'b0;
        rst_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (dr.dr_o_ack === 1'b1) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL rst_wait_lost got=%0d exp=0", acks); end
        do_access(1'b0, 32'h20, 4'h0, 32'h0, n, bp, ba, rd, e, aa);
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL rst_wait_mem got=%h exp=11111111", rd); end
        checks++; if (n !== 4) begin errors++; $display("FAIL rst_wait_idle got=%0d exp=4", n); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_store_load();
        test_byte_store();
        test_back_to_back();
        test_errors();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that services load/store requests issued by the pipeline's memory stage over a req/ack handshake.
- Requests complete after a parameterised number of wait states; the pipeline stalls on the busy output in the meantime.
- Stores use lane-aligned data with a 4-bit byte mask; loads return the full word, and sub-word extraction stays in the load-treatment logic.
- The block sits between the EX/MEM pipeline register and the MEM/WB register, replacing the fixed-latency data memory.

Parameters:
DWIDTH, 32, data and byte-address width.
DEPTH_LOG2, 10, log2 of the number of words in the array (1024 words = 4 KB).
WAIT_CYCLES, 2, wait states between acceptance and response (0..15).

Ports:
dr_clk  in  1  clock, rising edge.
dr_rst  in  1  reset, asynchronous, active-low.
dr_i_req  in  1  request valid; requester holds it and all fields stable until ack.
dr_i_we  in  1  1 = store, 0 = load.
dr_i_addr  in  DWIDTH  byte address (ALU result).
dr_i_mask  in  4  store byte enables; bit i enables dr_i_wdata[8i+7:8i].
dr_i_wdata  in  DWIDTH  lane-aligned store data.
dr_o_ack  out  1  one-cycle completion pulse, registered.
dr_o_rdata  out  DWIDTH  load data, valid when ack is high for a load.
dr_o_busy  out  1  pipeline stall: dr_i_req & ~dr_o_ack (combinational).
dr_o_err  out  1  error flag, pulses together with ack.

Behaviour:
- Reset (dr_rst low, asynchronous):
  - state = IDLE; ack, err and rdata = 0; wait counter = 0; captured request dropped.
  - Array contents are NOT reset.
  - A request that was in flight is lost; the requester must reissue it.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req is high at a clock edge: capture we/addr/mask/wdata.
  - Counter = WAIT_CYCLES - 1. Go to WAIT, or to RESP when WAIT_CYCLES = 0.
- WAIT: decrement the counter each cycle; go to RESP when it reaches 0. Input changes are ignored (captured copy is used).
- RESP (one cycle): perform the access, assert ack, return to IDLE.
- Latency: request sampled at edge k; ack is high during the cycle after edge k + WAIT_CYCLES + 1.
- Store:
  - Masked byte-lane write to word addr[DEPTH_LOG2+1:2].
  - Mask 0000: ack with no change.
  - rdata holds its previous value.
- Load:
  - rdata = array word, registered together with ack.
  - rdata holds until the next load completes.
- Error conditions (see Optional Feature):
  - addr[DWIDTH-1:DEPTH_LOG2+2] != 0 (out of range), or
  - mask = 1111 with addr[1:0] != 0 (misaligned word).
  - Response on error: no write; load rdata = 0; err = 1 with ack.
- Handshake:
  - req is never re-sampled in the RESP cycle, so a held request cannot be accepted twice.
  - The next request can be accepted in the IDLE cycle immediately after ack (back-to-back throughput = WAIT_CYCLES + 2 cycles per access).
- busy is high from req assertion until ack. It is low during the ack cycle so the pipeline advances on that edge.
- Simultaneous reset and ack: reset wins; ack is forced to 0.

Optional Feature:
- Macro: DR_ERR_CHECK_EN.
- Defined: range and alignment checks active as above.
- Undefined:
  - No checks; dr_o_err is tied to 0.
  - Address bits above DEPTH_LOG2+1 are ignored, so addresses wrap modulo 4·2^DEPTH_LOG2.
  - Misaligned word accesses use addr[DEPTH_LOG2+1:2].

Decomposition:
- Shared header:
  - DWIDTH define (already global).
  - FSM state localparams (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2).
  - Byte-mask width of 4.
- Sub-module dmem_bank: 2^DEPTH_LOG2 × 4 byte-lane array with synchronous masked write and registered read, enable-gated.
- The FSM, capture registers and error logic stay in dmem_responder.

Test Plan:
1. Reset: hold dr_rst low 3 cycles with req = 1 → ack = 0, err = 0, rdata = 0, busy = 1 (req & ~ack); after release, first acceptance occurs at the first rising edge.
2. WAIT_CYCLES = 2: store 0xDEADBEEF at 0x10 with mask 1111 → ack high exactly one cycle, 4 cycles after the sampling edge; busy low in that cycle. Then load 0x10 → rdata = 0xDEADBEEF with ack.
3. Byte store 0x00AA0000 at 0x10 with mask 0100, then load 0x10 → rdata = 0xDEAABEEF.
4. Back-to-back: two stores held continuously (second presented right after the first ack) → exactly 2 ack pulses, 4 cycles apart; each word written once.
5. DR_ERR_CHECK_EN defined, load 0x00001000 and store to 0x12 with mask 1111 → each gives err = 1 with ack, rdata = 0, memory unchanged. Undefined: load 0x00001000 returns word 0.
6. Reset asserted during WAIT of a store to 0x20 → no ack; state IDLE; a later load of 0x20 returns its previous value.
